// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE
  } state_t;

  // Ones in the low `len` bit positions; selects the live part of pattern/history.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register with saturating fill count and masked pattern compare.
module seq_match_core
  import seq_detect_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;

  assign hist_next = {history[MAX_LEN-2:0], x};
  assign fill_next = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
  assign hit       = shift_en && (fill_next >= len) &&
                     (((hist_next ^ pattern) & len_mask(len)) == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= hist_next;
      // Non-overlapping: a match consumes its bits, the next one needs a fresh fill.
      fill    <= hit ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config capture, arm/run/done sequencing, match and timeout counting.
module seq_detect_ctrl #(
  parameter int MAX_LEN = seq_detect_pkg::MAX_LEN,
  parameter int CNT_W   = seq_detect_pkg::CNT_W,
  parameter int TO_W    = seq_detect_pkg::TO_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic [TO_W-1:0]              cfg_timeout,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         x_valid,
  input  logic                         x,
  output logic                         z,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         timed_out,
  output logic                         cfg_err
);
  import seq_detect_pkg::*;

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t             state, state_next;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [TO_W-1:0]    to_q;
  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_next;
  logic               target_hit, to_expire, timeout_evt;
  logic               start_arm, start_done, shift_en, hit;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == ARMED);
  assign done      = (state == DONE);
  assign cfg_err   = (len_q == '0) || (len_q > LW'(MAX_LEN));

  assign target_hit  = (match_cnt == tgt_q);
  assign to_next     = to_cnt + 1'b1;
  assign to_expire   = (to_q != '0) && (to_next == to_q);
  // Once the target is met the run only waits one cycle to report done; no further bits count.
  assign shift_en    = busy && x_valid && !abort && !target_hit;
  assign timeout_evt = busy && !abort && !target_hit && to_expire && !hit;

  seq_match_core u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_arm),
    .shift_en(shift_en),
    .x       (x),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    start_arm  = 1'b0;
    start_done = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cfg_err) begin
          if (tgt_q != '0) begin
            state_next = ARMED;
            start_arm  = 1'b1;
          end else begin
            state_next = DONE;
            start_done = 1'b1;
          end
        end
      end
      ARMED: begin
        if (abort)            state_next = IDLE;
        else if (target_hit)  state_next = DONE;
        else if (timeout_evt) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      tgt_q     <= '0;
      to_q      <= '0;
      to_cnt    <= '0;
      match_cnt <= '0;
      z         <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state <= state_next;
      z     <= hit;
      // Start in the same cycle still sees the old config; the new one lands here.
      if (cfg_ready && cfg_valid) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        tgt_q <= cfg_target;
        to_q  <= cfg_timeout;
      end
      if (start_arm || start_done) begin
        match_cnt <= '0;
        to_cnt    <= '0;
        timed_out <= 1'b0;
      end else if (busy && !abort) begin
        if (hit) begin
          match_cnt <= match_cnt + 1'b1;
          to_cnt    <= '0;
        end else if (to_q != '0) begin
          to_cnt <= to_next;
        end
        if (timeout_evt) timed_out <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run controller for a programmable, non-overlapping serial pattern detector.
- Accepts a pattern configuration (bits, length, match target, timeout) through a valid/ready handshake.
- Arms detection on `start`, consumes a qualified serial bit stream, and counts matches.
- Ends the run with a `done` pulse when the target count is reached or the timeout expires.
- Serves as the sequencing/configuration wrapper that replaces per-pattern hard-coded detector FSMs.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits.
- CNT_W, 8: width of the match target and match counter.
- TO_W, 16: width of the timeout counter, in clk cycles.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- cfg_valid, input, 1: configuration offered.
- cfg_ready, output, 1: configuration accepted this cycle; high only in IDLE.
- cfg_pattern, input, MAX_LEN: pattern. Bit cfg_len-1 is received first; bit 0 is received last.
- cfg_len, input, $clog2(MAX_LEN+1): pattern length. Legal range 1..MAX_LEN.
- cfg_target, input, CNT_W: number of matches that ends the run.
- cfg_timeout, input, TO_W: cycles without a match before abort. 0 disables the timeout.
- start, input, 1: begin a run (IDLE only).
- abort, input, 1: cancel the run.
- x_valid, input, 1: x is a new bit this cycle.
- x, input, 1: serial data bit.
- z, output, 1: one-cycle match pulse, registered.
- match_cnt, output, CNT_W: matches in the current or last run.
- busy, output, 1: high in ARMED.
- done, output, 1: one-cycle end-of-run pulse.
- timed_out, output, 1: last run ended by timeout. Sticky until the next accepted start.
- cfg_err, output, 1: stored cfg_len is 0 or greater than MAX_LEN.

Behaviour:
- Reset (async): state=IDLE; z=0, match_cnt=0, busy=0, done=0, timed_out=0; stored config all zeros, so cfg_err=1; history cleared.
- States: IDLE, ARMED, DONE.
- IDLE:
  - cfg_ready=1; cfg_valid stores all cfg fields at the clock edge.
  - start with cfg_err=0 and target≠0: go to ARMED; clear match_cnt, history, timeout counter and timed_out.
  - start with cfg_err=0 and target=0: go to DONE; match_cnt=0.
  - start with cfg_err=1: ignored; stay in IDLE.
  - start and cfg_valid in the same cycle: start uses the previously stored config; the new config is stored.
- ARMED:
  - On x_valid, shift x into the MAX_LEN-bit history (new bit at LSB) and increment fill, saturating at MAX_LEN.
  - Match: x_valid, fill_next ≥ len, and the low len bits of the next history equal the low len bits of the pattern.
  - On match: z=1 next cycle; match_cnt+1; history fill cleared to 0 (non-overlapping, so the next match needs len fresh bits); timeout counter cleared.
  - Timeout counter increments every clk (regardless of x_valid) when timeout≠0. When it reaches cfg_timeout with no match that cycle, go to DONE with timed_out=1.
  - match_cnt reaching target goes to DONE with timed_out=0.
  - Match and timeout in the same cycle: the match wins and the timeout counter clears.
  - abort has top priority: go to IDLE next cycle. No done pulse, no z, match_cnt holds, timed_out=0.
  - x ignored when x_valid=0. cfg_valid ignored (cfg_ready=0).
- DONE: lasts one cycle; done=1, busy=0. Unconditionally returns to IDLE, so start/abort in DONE are ignored. match_cnt and timed_out hold.
- Latency: the bit completing a pattern is sampled at edge N; z is 1 during cycle N+1. If that match hits the target, done is 1 during cycle N+2.
- match_cnt never wraps: the run ends at target, and target ≤ 2^CNT_W-1.
- Reset mid-run returns everything to reset values immediately; no done pulse.

Decomposition:
- Package seq_detect_pkg:
  - state enum {IDLE, ARMED, DONE};
  - localparam LEN_W = $clog2(MAX_LEN+1);
  - function len_mask(len) returning a MAX_LEN-bit mask.
- One sub-module, seq_match_core: history shift register, fill counter and masked compare. Outputs a combinational `hit`; takes a `clr` input.
- FSM, counters and config registers live in the top level.

Test Plan:
- Config 101111 (len 6), target 2, timeout 0; stream 101111 101111 → z pulses after bits 6 and 12; match_cnt=2; done one cycle after the second z; timed_out=0.
- Pattern 11 (len 2), target 3; stream 1111 → exactly 2 z pulses (bits 2 and 4, none at bit 3); match_cnt=2; still busy.
- Pattern 101, timeout 10; stream of all zeros → done at cycle 10 after arm; timed_out=1; match_cnt=0.
- Abort during ARMED after 1 match → IDLE next cycle; no done; match_cnt=1. A subsequent start clears match_cnt to 0.
- cfg_len=0 stored → cfg_err=1; start ignored and busy stays 0. Reload len 3 → cfg_err=0; start arms.
- rst asserted mid-run between clock edges → outputs zero immediately; cfg_err=1; run does not resume after rst release.
